// File: rtl/jtframe_rom_resp.sv
// ROM port responder: turns a 32-bit read request into two 16-bit memory reads
// and turns download byte writes into single masked memory writes.
module jtframe_rom_resp #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          sdram_req,
    input  logic [AW-1:0] sdram_addr,
    output logic          sdram_ack,
    output logic          data_dst,
    output logic          data_rdy,
    output logic [31:0]   data_read,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic [1:0]    mem_dqm,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LO   = 3'd1,
        RD_HI   = 3'd2,
        WR      = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_inc_s;

    // Upper word address; natural AW-bit overflow gives the wrap to zero.
    assign addr_inc_s = addr_r + {{(AW-1){1'b0}}, 1'b1};

    // Access sequencer with registered handshake and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            addr_r    <= {AW{1'b0}};
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= 16'd0;
            mem_dqm   <= 2'b00;
        end else begin
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (downloading && prog_we) begin
                        state_r   <= WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= prog_addr;
                        mem_wdata <= {prog_data, prog_data};
                        mem_dqm   <= prog_mask;
                    end else if (!downloading && sdram_req) begin
                        state_r   <= RD_LO;
                        addr_r    <= sdram_addr;
                        sdram_ack <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= sdram_addr;
                        mem_dqm   <= 2'b00;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                // The request stays up across the two halves so the upper
                // word is issued right after the lower one completes.
                RD_LO: begin
                    if (mem_ack) begin
                        state_r         <= RD_HI;
                        data_read[15:0] <= mem_rdata;
                        data_dst        <= 1'b1;
                        mem_addr        <= addr_inc_s;
                    end else begin
                        state_r         <= RD_LO;
                    end
                end
                RD_HI: begin
                    if (mem_ack) begin
                        state_r          <= IDLE;
                        data_read[31:16] <= mem_rdata;
                        data_rdy         <= 1'b1;
                        mem_req          <= 1'b0;
                    end else begin
                        state_r          <= RD_HI;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state_r   <= WR_WAIT;
                        sdram_ack <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                    end else begin
                        state_r   <= WR;
                    end
                end
                // Hold here until the requester releases prog_we so a long
                // write strobe is not taken as a second write.
                WR_WAIT: begin
                    if (!prog_we) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_resp.sv
// Directed bench for jtframe_rom_resp with a one-cycle-ack memory model.
module tb_jtframe_rom_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_dqm;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0, dst_cnt = 0, rdy_cnt = 0, excl_err = 0;
    int wr_cnt = 0;
    logic [21:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_dqm;
    logic [21:0] rd_log[$];
    bit mem_auto = 1'b1;
    bit inject_ack = 1'b0;

    jtframe_rom_resp #(.AW(22)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy),
        .data_read(data_read), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dqm(mem_dqm),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [21:0] a);
        if (a == 22'h01234) return 16'hBEEF;
        else if (a == 22'h01235) return 16'hCAFE;
        else return {a[7:0], ~a[7:0]};
    endfunction

    // Memory model: ack one cycle after a request is seen, data valid with ack.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_ack   <= (mem_auto && mem_req && !mem_ack) || inject_ack;
        mem_rdata <= mem_val(mem_addr);
        if (mem_ack && mem_req && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_dqm  <= mem_dqm;
        end
        if (mem_ack && mem_req && !mem_we) rd_log.push_back(mem_addr);
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (sdram_ack) ack_cnt++;
        if (data_dst)  dst_cnt++;
        if (data_rdy)  rdy_cnt++;
        if ((32'(sdram_ack) + 32'(data_dst) + 32'(data_rdy)) > 1) excl_err++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // which: 0 = sdram_ack, 1 = data_dst, 2 = data_rdy
    task automatic wait_pulse(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((which == 0 && sdram_ack) || (which == 1 && data_dst) ||
                (which == 2 && data_rdy)) begin
                ok = 1'b1;
                return;
            end
        end
        chk($sformatf("timeout_wait_%0d", which), 64'd0, 64'd1);
    endtask

    task automatic do_read(input logic [21:0] a, input int drop_after,
                           output int t_ack, output int t_dst, output int t_rdy,
                           output logic [15:0] lo, output logic [31:0] full);
        int t0;
        bit ok;
        @(negedge clk);
        sdram_addr = a;
        sdram_req  = 1'b1;
        t0 = cyc;
        wait_pulse(0, ok);
        t_ack = cyc - t0;
        repeat (drop_after) @(negedge clk);
        sdram_req = 1'b0;
        wait_pulse(1, ok);
        t_dst = cyc - t0;
        lo = data_read[15:0];
        wait_pulse(2, ok);
        t_rdy = cyc - t0;
        full = data_read;
    endtask

    task automatic do_write(input logic [21:0] a, input logic [7:0] d,
                            input logic [1:0] m, input int extra);
        bit ok;
        @(negedge clk);
        downloading = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        prog_we   = 1'b1;
        @(negedge clk);
        chk("wr_req_we", {62'd0, mem_req, mem_we}, 64'd3);
        chk("wr_addr_out", 64'(mem_addr), 64'(a));
        wait_pulse(0, ok);
        repeat (extra) @(negedge clk);
        prog_we = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int ta, td, tr, ta2, tr1, w0, a0, r0, d0;
        bit ok;
        logic [15:0] lo;
        logic [31:0] full;

        rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; prog_addr = 22'd0;
        prog_data = 8'd0; prog_mask = 2'b00; sdram_req = 1'b0; sdram_addr = 22'd0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {57'd0, sdram_ack, data_dst, data_rdy, mem_req, mem_we, mem_dqm}, 64'd0);
        chk("rst_data_read", 64'(data_read), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic read with latency figures
        rd_log.delete(); a0 = ack_cnt;
        do_read(22'h01234, 0, ta, td, tr, lo, full);
        repeat (2) @(negedge clk);
        chk("rd_t_ack", 64'(ta), 64'd1);
        chk("rd_t_dst", 64'(td), 64'd3);
        chk("rd_t_rdy", 64'(tr), 64'd5);
        chk("rd_lo", 64'(lo), 64'hBEEF);
        chk("rd_full", 64'(full), 64'hCAFE_BEEF);
        chk("rd_log_n", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2) begin
            chk("rd_addr0", 64'(rd_log[0]), 64'h01234);
            chk("rd_addr1", 64'(rd_log[1]), 64'h01235);
        end
        chk("rd_ack_once", 64'(ack_cnt - a0), 64'd1);
        chk("rd_req_drop", 64'(mem_req), 64'd0);

        // Address wrap
        rd_log.delete();
        do_read(22'h3F_FFFF, 0, ta, td, tr, lo, full);
        repeat (2) @(negedge clk);
        chk("wrap_full", 64'(full), 64'h00FF_FF00);
        chk("wrap_log_n", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2) chk("wrap_addr1", 64'(rd_log[1]), 64'h0);

        // Request dropped one cycle after ack
        do_read(22'h00050, 1, ta, td, tr, lo, full);
        repeat (2) @(negedge clk);
        chk("drop_t_rdy", 64'(tr), 64'd5);
        chk("drop_full", 64'(full), 64'h51AE_50AF);

        // Write with prog_we held 3 extra cycles
        w0 = wr_cnt; a0 = ack_cnt;
        do_write(22'h00100, 8'h5A, 2'b10, 3);
        chk("wr_count", 64'(wr_cnt - w0), 64'd1);
        chk("wr_mem_addr", 64'(wr_addr), 64'h00100);
        chk("wr_wdata", 64'(wr_data), 64'h5A5A);
        chk("wr_dqm", 64'(wr_dqm), 64'h2);
        chk("wr_ack_once", 64'(ack_cnt - a0), 64'd1);

        // Both requests while downloading: write only
        rd_log.delete(); w0 = wr_cnt; a0 = ack_cnt;
        sdram_addr = 22'h00777; sdram_req = 1'b1;
        do_write(22'h00200, 8'hC3, 2'b01, 0);
        sdram_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("dl_wr_count", 64'(wr_cnt - w0), 64'd1);
        chk("dl_no_read", 64'(rd_log.size()), 64'd0);
        chk("dl_ack_once", 64'(ack_cnt - a0), 64'd1);
        chk("dl_wdata", 64'(wr_data), 64'hC3C3);

        // Both requests while not downloading: read only
        downloading = 1'b0; w0 = wr_cnt; r0 = rdy_cnt;
        prog_addr = 22'h00300; prog_we = 1'b1;
        do_read(22'h00060, 0, ta, td, tr, lo, full);
        repeat (2) @(negedge clk);
        prog_we = 1'b0;
        chk("nd_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("nd_rdy_once", 64'(rdy_cnt - r0), 64'd1);
        chk("nd_full", 64'(full), 64'h619E_609F);

        // Back-to-back reads with sdram_req held
        @(negedge clk);
        sdram_addr = 22'h00210; sdram_req = 1'b1;
        wait_pulse(0, ok);
        sdram_addr = 22'h00320;
        wait_pulse(2, ok);
        tr1 = cyc;
        chk("b2b_full1", 64'(data_read), 64'h11EE_10EF);
        wait_pulse(0, ok);
        ta2 = cyc;
        sdram_req = 1'b0;
        chk("b2b_gap_ok", 64'((ta2 - tr1) <= 2), 64'd1);
        wait_pulse(2, ok);
        chk("b2b_full2", 64'(data_read), 64'h21DE_20DF);
        repeat (2) @(negedge clk);

        // Reset in RD_HI, then a late mem_ack
        mem_auto = 1'b0;
        @(negedge clk);
        sdram_addr = 22'h00040; sdram_req = 1'b1;
        wait_pulse(0, ok);
        sdram_req = 1'b0; inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        wait_pulse(1, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_ctrl", {57'd0, sdram_ack, data_dst, data_rdy, mem_req, mem_we, mem_dqm}, 64'd0);
        chk("ab_data_read", 64'(data_read), 64'd0);
        chk("ab_mem_addr", 64'(mem_addr), 64'd0);
        a0 = ack_cnt; d0 = dst_cnt; r0 = rdy_cnt;
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_late_ack_idle", 64'(mem_req), 64'd0);
        chk("ab_no_pulses", 64'((ack_cnt - a0) + (dst_cnt - d0) + (rdy_cnt - r0)), 64'd0);
        mem_auto = 1'b1;
        do_read(22'h00050, 0, ta, td, tr, lo, full);
        repeat (2) @(negedge clk);
        chk("ab_next_t_rdy", 64'(tr), 64'd5);
        chk("ab_next_full", 64'(full), 64'h51AE_50AF);

        chk("pulse_exclusive", 64'(excl_err), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
